promfetch: RTL

Program-ROM fetch sequencer on the 68k side of the cartridge bus. It issues one-cycle `a68kreq` pulses to the bus sampler and collects each returned 19-bit word address on `a68kack` into a 2-entry FIFO. It reads each queued address from the backing memory over a req/ack handshake and presents the 16-bit word to the 68k data driver with a one-cycle `dvalid` strobe. It sits directly downstream of the bus-sampling CPLD logic and upstream of the data driver and memory controller.

---
 rtl/promfetch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/promfetch.sv
// Program-ROM fetch sequencer: issues bus-sampler requests, queues returned word
// addresses, reads them from backing memory and strobes each word out. Optional
// one-entry hit cache is enabled by defining PROMFETCH_HITCACHE_EN.
module promfetch #(
    parameter logic [22:0] BASE = 23'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        flush,
    output logic        a68kreq,
    input  logic [18:0] a68kaddr,
    input  logic        a68kack,
    output logic        memreq,
    output logic [22:0] memaddr,
    input  logic        memack,
    input  logic [15:0] memdata,
    output logic [15:0] dout,
    output logic        dvalid,
    output logic [1:0]  qcount
);

    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

    state_t      state, state_nxt;
    logic        pending;
    logic        drop;
    logic [18:0] fifo0, fifo1;
    logic [22:0] head_addr;
    logic        issue, push, pop, miss_pop;
    logic        mem_done, fetch_done, deliver;
    logic [15:0] ret_data;

    assign head_addr = BASE + {3'b000, fifo0, 1'b0};
    assign issue     = run && !pending && (qcount != 2'd2) && !flush && !a68kreq;
    assign push      = a68kack && pending && !flush;
    assign pop       = (state == IDLE) && (qcount != 2'd0) && !flush;
    assign mem_done  = (state == FETCH) && memreq && memack;
    // A result is discarded if a flush arrived at any point during its fetch.
    assign deliver   = fetch_done && !drop && !flush;

`ifdef PROMFETCH_HITCACHE_EN
    logic        cache_valid;
    logic        hit_pend;
    logic [22:0] cache_addr;
    logic [15:0] cache_data;
    logic        cache_hit;

    assign cache_hit  = cache_valid && (cache_addr == head_addr);
    assign miss_pop   = pop && !cache_hit;
    assign fetch_done = (state == FETCH) && (hit_pend || (memreq && memack));
    assign ret_data   = hit_pend ? cache_data : memdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
            hit_pend    <= 1'b0;
        end else begin
            if (flush) begin
                cache_valid <= 1'b0;
            end else if (mem_done && !drop) begin
                cache_valid <= 1'b1;
                cache_addr  <= memaddr;
                cache_data  <= memdata;
            end
            if (pop && cache_hit) begin
                hit_pend <= 1'b1;
            end else if (fetch_done) begin
                hit_pend <= 1'b0;
            end
        end
    end
`else
    assign miss_pop   = pop;
    assign fetch_done = mem_done;
    assign ret_data   = memdata;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = FETCH;
            FETCH:   if (fetch_done) state_nxt = deliver ? DELIVER : IDLE;
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a68kreq <= 1'b0;
            pending <= 1'b0;
            drop    <= 1'b0;
            fifo0   <= '0;
            fifo1   <= '0;
            qcount  <= 2'd0;
            memreq  <= 1'b0;
            memaddr <= '0;
            dout    <= '0;
            dvalid  <= 1'b0;
        end else begin
            state   <= state_nxt;
            a68kreq <= issue;

            if (flush) begin
                pending <= 1'b0;
            end else if (issue) begin
                pending <= 1'b1;
            end else if (push) begin
                pending <= 1'b0;
            end

            // Push with pop only happens at occupancy 1, so the new entry becomes head.
            if (flush) begin
                qcount <= 2'd0;
            end else if (push && !pop) begin
                qcount <= qcount + 2'd1;
                if (qcount == 2'd0) fifo0 <= a68kaddr;
                else                fifo1 <= a68kaddr;
            end else if (pop && !push) begin
                qcount <= qcount - 2'd1;
                fifo0  <= fifo1;
            end else if (push && pop) begin
                fifo0 <= a68kaddr;
            end

            drop <= (state == FETCH) && !fetch_done && (drop || flush);

            if (pop) begin
                memaddr <= head_addr;
            end
            if (miss_pop) begin
                memreq <= 1'b1;
            end else if (mem_done) begin
                memreq <= 1'b0;
            end

            dvalid <= deliver;
            if (deliver) begin
                dout <= ret_data;
            end
        end
    end

endmodule
